fetch_unit: RTL

- Instruction-fetch initiator. Drives chip-enable and address into the combinational instruction ROM and captures the returned word in the same cycle.
- Buffers fetched {pc, inst} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch redirects from later stages and flushes all buffered instructions on a redirect.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: drives the combinational ROM, queues {pc, inst} pairs and hands them to decode.
// Optional FETCH_ALIGN_CHK_EN: flags misaligned pcs, pushes a marked entry and halts until the next redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
`ifdef FETCH_ALIGN_CHK_EN
  output logic [31:0] id_inst_o,
  output logic        id_misalign_o
`else
  output logic [31:0] id_inst_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [31:0]   ZERO_WORD = 32'h0000_0000;

  logic          en_r;
  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];

  logic          pop;
  logic          room;
  logic          push;
  logic [31:0]   push_inst;

  // Decode handshake: an entry transfers on every rising edge where id_valid_o
  // and id_ready_i are both high; the head is held stable while valid && !ready.
  assign id_valid_o = (count != '0);
  assign pop        = id_valid_o & id_ready_i;
  assign room       = (count < DEPTH_C) | pop;
  assign rom_addr_o = pc;

`ifdef FETCH_ALIGN_CHK_EN
  logic halt;
  logic misalign;
  logic mem_mis [DEPTH];

  assign misalign  = (pc[1:0] != 2'b00);
  assign push      = en_r & ~branch_flag_i & ~halt & room;
  assign rom_ce_o  = push & ~misalign;
  assign push_inst = misalign ? ZERO_WORD : rom_inst_i;
  assign id_misalign_o = id_valid_o & mem_mis[rd_ptr];

  // A misaligned fetch stops the front end until decode redirects it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt <= 1'b0;
    end else if (branch_flag_i) begin
      halt <= 1'b0;
    end else if (push & misalign) begin
      halt <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_mis[wr_ptr] <= misalign;
    end
  end
`else
  assign push      = en_r & ~branch_flag_i & room;
  assign rom_ce_o  = push;
  assign push_inst = rom_inst_i;
`endif

  assign id_pc_o   = id_valid_o ? mem_pc[rd_ptr]   : ZERO_WORD;
  assign id_inst_o = id_valid_o ? mem_inst[rd_ptr] : ZERO_WORD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r   <= 1'b0;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      en_r <= 1'b1;
      if (branch_flag_i) begin
        // Redirect wins: any same-cycle pop is a completed handoff, the rest is dropped.
        pc     <= branch_target_i;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= pc;
      mem_inst[wr_ptr] <= push_inst;
    end
  end

endmodule
